bram_arbiter: RTL and testbench

- Two-requester round-robin arbiter in front of bram_if_ctrl, sharing one BRAM port between two clients, e.g. a frame loader (port 0) and a processing engine (port 1).
- Captures one command per grant and drives the controller's en/wr/addr_in/wdata_in for exactly one cycle.
- For reads, holds ownership until rdata_rdy and routes rdata_out back to the owning requester.
- At most one transaction is in flight at any time.

---
 rtl/bram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bram_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter sharing one bram_if_ctrl port; one transaction in flight.
// Optional read-timeout abort is enabled by defining BRAM_ARB_TIMEOUT_EN.
module bram_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rdata_vld0,
    output logic              rdata_vld1,
    output logic [DATA_W-1:0] rdata,
    output logic              en,
    output logic              wr,
    output logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] wdata_in,
    input  logic              rdata_rdy,
    input  logic [DATA_W-1:0] rdata_out,
    output logic              busy,
    output logic              rd_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                last_owner_r, last_owner_s;
    logic                gnt0_r, gnt0_s, gnt1_r, gnt1_s;
    logic                vld0_r, vld0_s, vld1_r, vld1_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                en_r, en_s, wr_r, wr_s;
    logic [ADDR_W-1:0]   addr_in_r, addr_in_s;
    logic [DATA_W-1:0]   wdata_in_r, wdata_in_s;
    logic                busy_r;

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                rd_err_r, rd_err_s;
`endif

    // Next state, captured command and next values of every registered output
    always_comb begin
        state_s      = state_r;
        last_owner_s = last_owner_r;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        vld0_s       = 1'b0;
        vld1_s       = 1'b0;
        rdata_s      = rdata_r;
        en_s         = 1'b0;
        wr_s         = wr_r;
        addr_in_s    = addr_in_r;
        wdata_in_s   = wdata_in_r;
`ifdef BRAM_ARB_TIMEOUT_EN
        cnt_s        = cnt_r;
        rd_err_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                // Port 0 wins when alone or when port 1 owned the previous transaction
                if (req0 && (!req1 || last_owner_r)) begin
                    last_owner_s = 1'b0;
                    wr_s         = wr0;
                    addr_in_s    = addr0;
                    wdata_in_s   = wdata0;
                    en_s         = 1'b1;
                    gnt0_s       = 1'b1;
                    state_s      = ISSUE;
                end else if (req1) begin
                    last_owner_s = 1'b1;
                    wr_s         = wr1;
                    addr_in_s    = addr1;
                    wdata_in_s   = wdata1;
                    en_s         = 1'b1;
                    gnt1_s       = 1'b1;
                    state_s      = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (wr_r) begin
                    state_s = IDLE;
                end else if (rdata_rdy) begin
                    rdata_s = rdata_out;
                    vld0_s  = ~last_owner_r;
                    vld1_s  = last_owner_r;
                    state_s = IDLE;
                end else begin
                    state_s = RD_WAIT;
`ifdef BRAM_ARB_TIMEOUT_EN
                    cnt_s   = '0;
`endif
                end
            end
            RD_WAIT: begin
                if (rdata_rdy) begin
                    rdata_s = rdata_out;
                    vld0_s  = ~last_owner_r;
                    vld1_s  = last_owner_r;
                    state_s = IDLE;
`ifdef BRAM_ARB_TIMEOUT_EN
                // cnt_r counts completed wait cycles; abort on the cycle it would reach RD_TIMEOUT
                end else if (cnt_r == CNT_W'(RD_TIMEOUT - 1)) begin
                    rdata_s  = '0;
                    vld0_s   = ~last_owner_r;
                    vld1_s   = last_owner_r;
                    rd_err_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = RD_WAIT;
                end
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            last_owner_r <= last_owner_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            vld0_r     <= 1'b0;
            vld1_r     <= 1'b0;
            rdata_r    <= '0;
            en_r       <= 1'b0;
            wr_r       <= 1'b0;
            addr_in_r  <= '0;
            wdata_in_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            gnt0_r     <= gnt0_s;
            gnt1_r     <= gnt1_s;
            vld0_r     <= vld0_s;
            vld1_r     <= vld1_s;
            rdata_r    <= rdata_s;
            en_r       <= en_s;
            wr_r       <= wr_s;
            addr_in_r  <= addr_in_s;
            wdata_in_r <= wdata_in_s;
            busy_r     <= (state_s != IDLE);
        end
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    // Read-wait counter and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            rd_err_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            rd_err_r <= rd_err_s;
        end
    end
    assign rd_err = rd_err_r;
`else
    assign rd_err = 1'b0;
`endif

    assign gnt0       = gnt0_r;
    assign gnt1       = gnt1_r;
    assign rdata_vld0 = vld0_r;
    assign rdata_vld1 = vld1_r;
    assign rdata      = rdata_r;
    assign en         = en_r;
    assign wr         = wr_r;
    assign addr_in    = addr_in_r;
    assign wdata_in   = wdata_in_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: emulated BRAM controller, per-port command queues,
// and a transaction-level model of round-robin ordering and memory contents.
module tb_bram_arbiter;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1, addr_in;
    logic [DATA_W-1:0] wdata0, wdata1, wdata_in, rdata, rdata_out;
    logic gnt0, gnt1, rdata_vld0, rdata_vld1, en, wr, rdata_rdy, busy, rd_err;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata_vld0(rdata_vld0), .rdata_vld1(rdata_vld1),
        .rdata(rdata), .en(en), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .rdata_rdy(rdata_rdy), .rdata_out(rdata_out), .busy(busy), .rd_err(rd_err)
    );

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct {
        int                port;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } rec_t;

    cmd_t q0[$], q1[$];
    rec_t ilog[$], vlog[$], exp_iss[$], exp_rd[$];
    int   errlog[$];
    logic [DATA_W-1:0] bram [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_mem [logic [ADDR_W-1:0]];
    int   model_last = 1;
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   lat = 0, pend = 0, cnt = 0;
    bit   stall = 1'b0, spur = 1'b0;
    logic [DATA_W-1:0] rd_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller emulation and transaction logging, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            rdata_rdy = 1'b0;
        end else begin
            rdata_rdy = spur;
            if (spur) rdata_out = 8'hEE;
            if (pend != 0) begin
                if (cnt == 0) begin
                    rdata_rdy = 1'b1;
                    rdata_out = rd_data;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (en && !wr) begin
                rd_data = bram.exists(addr_in) ? bram[addr_in] : 8'h00;
                if (stall) pend = 0;
                else if (lat == 0) begin
                    rdata_rdy = 1'b1;
                    rdata_out = rd_data;
                end else begin
                    pend = 1;
                    cnt = lat - 1;
                end
            end
            if (en && wr) bram[addr_in] = wdata_in;
            if (en)
                ilog.push_back('{(gnt0 && !gnt1) ? 0 : ((gnt1 && !gnt0) ? 1 : -1), wr, addr_in, wdata_in, cyc});
            if (rdata_vld0 || rdata_vld1)
                vlog.push_back('{(rdata_vld0 && !rdata_vld1) ? 0 : ((rdata_vld1 && !rdata_vld0) ? 1 : -1), 1'b0, '0, rdata, cyc});
            if (rd_err) errlog.push_back(cyc);
        end
    end

    task automatic set_inputs();
        req0 = (q0.size() > 0);
        if (q0.size() > 0) begin wr0 = q0[0].wr; addr0 = q0[0].addr; wdata0 = q0[0].data; end
        req1 = (q1.size() > 0);
        if (q1.size() > 0) begin wr1 = q1[0].wr; addr1 = q1[0].addr; wdata1 = q1[0].data; end
    endtask

    // Requesters: advance to the next command once the grant is seen
    task automatic run(input int max_cyc, input string name);
        int n = 0;
        bit done = 1'b0;
        cmd_t tmp;
        while (!done) begin
            @(posedge clk); #1;
            if (gnt0 && q0.size() > 0) tmp = q0.pop_front();
            if (gnt1 && q1.size() > 0) tmp = q1.pop_front();
            set_inputs();
            n++;
            if (q0.size() == 0 && q1.size() == 0 && !busy) done = 1'b1;
            else if (n >= max_cyc) begin
                checks++; errors++;
                $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
                done = 1'b1;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int port, input string name);
        int n = 0;
        bit got = 1'b0;
        cmd_t tmp;
        while (!got && n < 50) begin
            @(posedge clk); #1;
            n++;
            got = (port == 0) ? gnt0 : gnt1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_gnt%0d: no grant within %0d cycles, required a grant", name, port, n);
        end else if (port == 0 && q0.size() > 0) tmp = q0.pop_front();
        else if (port == 1 && q1.size() > 0) tmp = q1.pop_front();
        set_inputs();
    endtask

    // Both ports start pending together: the winner of each contention is the port that did not win last
    task automatic predict();
        cmd_t a[$], b[$], c;
        int p;
        a = q0; b = q1;
        exp_iss.delete(); exp_rd.delete();
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() > 0 && b.size() > 0) p = 1 - model_last;
            else p = (a.size() > 0) ? 0 : 1;
            c = (p == 0) ? a.pop_front() : b.pop_front();
            model_last = p;
            exp_iss.push_back('{p, c.wr, c.addr, c.data, 0});
            if (c.wr) exp_mem[c.addr] = c.data;
            else exp_rd.push_back('{p, 1'b0, c.addr, exp_mem.exists(c.addr) ? exp_mem[c.addr] : 8'h00, 0});
        end
    endtask

    task automatic check_logs(input string name);
        checks++;
        if (ilog.size() != exp_iss.size()) begin
            errors++;
            $display("FAIL %s_issue_count: got %0d, required %0d", name, ilog.size(), exp_iss.size());
        end
        for (int i = 0; i < ilog.size() && i < exp_iss.size(); i++) begin
            checks++;
            if (ilog[i].port !== exp_iss[i].port || ilog[i].wr !== exp_iss[i].wr ||
                ilog[i].addr !== exp_iss[i].addr || (exp_iss[i].wr && ilog[i].data !== exp_iss[i].data)) begin
                errors++;
                $display("FAIL %s_issue[%0d]: got port %0d wr %0b addr %h data %h, required port %0d wr %0b addr %h data %h",
                         name, i, ilog[i].port, ilog[i].wr, ilog[i].addr, ilog[i].data,
                         exp_iss[i].port, exp_iss[i].wr, exp_iss[i].addr, exp_iss[i].data);
            end
        end
        checks++;
        if (vlog.size() != exp_rd.size()) begin
            errors++;
            $display("FAIL %s_read_count: got %0d, required %0d", name, vlog.size(), exp_rd.size());
        end
        for (int i = 0; i < vlog.size() && i < exp_rd.size(); i++) begin
            checks++;
            if (vlog[i].port !== exp_rd[i].port || vlog[i].data !== exp_rd[i].data) begin
                errors++;
                $display("FAIL %s_read[%0d]: got port %0d data %h, required port %0d data %h",
                         name, i, vlog[i].port, vlog[i].data, exp_rd[i].port, exp_rd[i].data);
            end
        end
    endtask

    task automatic do_traffic(input string name);
        predict();
        ilog.delete(); vlog.delete();
        set_inputs();
        run(2000, name);
        check_logs(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rdata_rdy = 1'b0; rdata_out = '0;
        #2 rst_n = 1'b0;
        #5;
        checks++;
        if ({gnt0, gnt1, rdata_vld0, rdata_vld1, rdata, en, wr, addr_in, wdata_in, busy, rd_err} !== '0) begin
            errors++;
            $display("FAIL reset_in: outputs not all zero during reset, required 0");
        end
        #22 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({gnt0, gnt1, rdata_vld0, rdata_vld1, rdata, en, wr, addr_in, wdata_in, busy, rd_err} !== '0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d busy %0b en %0b gnt %0b%0b, required all outputs 0", i, busy, en, gnt0, gnt1);
            end
        end
    endtask

    task automatic test_single();
        q0.push_back('{1'b1, 17'h12345, 8'hA5});
        do_traffic("single_write");
        lat = 3;
        q0.push_back('{1'b0, 17'h12345, 8'h00});
        do_traffic("single_read");
        checks++;
        if (ilog.size() != 1 || vlog.size() != 1 || vlog[0].cyc - ilog[0].cyc != 4) begin
            errors++;
            $display("FAIL single_read_latency: got %0d, required 4 cycles from issue to rdata_vld",
                     (ilog.size() == 1 && vlog.size() == 1) ? vlog[0].cyc - ilog[0].cyc : -1);
        end
        lat = 0;
        q0.push_back('{1'b0, 17'h12345, 8'h00});
        do_traffic("zero_wait_read");
        checks++;
        if (ilog.size() != 1 || vlog.size() != 1 || vlog[0].cyc - ilog[0].cyc != 1) begin
            errors++;
            $display("FAIL zero_wait_latency: got %0d, required 1 cycle from issue to rdata_vld",
                     (ilog.size() == 1 && vlog.size() == 1) ? vlog[0].cyc - ilog[0].cyc : -1);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b1, 17'(32'h100 + i), 8'(8'h10 + i)});
            q1.push_back('{1'b1, 17'(32'h200 + i), 8'(8'h20 + i)});
        end
        do_traffic("contention");
        for (int i = 1; i < ilog.size(); i++) begin
            checks++;
            if (ilog[i].cyc - ilog[i-1].cyc != 2 || ilog[i].port == ilog[i-1].port) begin
                errors++;
                $display("FAIL contention_spacing[%0d]: got gap %0d ports %0d,%0d, required gap 2 alternating ports",
                         i, ilog[i].cyc - ilog[i-1].cyc, ilog[i-1].port, ilog[i].port);
            end
        end
    endtask

    task automatic test_read_in_flight();
        logic [DATA_W-1:0] exp_d;
        exp_d = exp_mem[17'h12345];
        lat = 3;
        ilog.delete(); vlog.delete();
        q1.push_back('{1'b0, 17'h12345, 8'h00});
        set_inputs();
        wait_gnt(1, "in_flight");
        q0.push_back('{1'b1, 17'h00ABC, 8'h3C});
        set_inputs();
        run(200, "in_flight");
        exp_mem[17'h00ABC] = 8'h3C;
        model_last = 0;
        checks++;
        if (ilog.size() != 2 || vlog.size() != 1) begin
            errors++;
            $display("FAIL in_flight_count: got %0d issues %0d reads, required 2 and 1", ilog.size(), vlog.size());
        end else begin
            checks++;
            if (vlog[0].port != 1 || vlog[0].data !== exp_d) begin
                errors++;
                $display("FAIL in_flight_read: got port %0d data %h, required port 1 data %h", vlog[0].port, vlog[0].data, exp_d);
            end
            checks++;
            if (ilog[1].port != 0 || ilog[1].wr !== 1'b1 || ilog[1].cyc != vlog[0].cyc + 1) begin
                errors++;
                $display("FAIL in_flight_gnt0: got port %0d at cycle %0d, required port 0 at cycle %0d",
                         ilog[1].port, ilog[1].cyc, vlog[0].cyc + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] addrs[$];
        cmd_t c;
        for (int i = 0; i < 20; i++) begin
            c.wr = 1'b1;
            c.addr = 17'($urandom_range(0, 131071));
            c.data = 8'($urandom);
            addrs.push_back(c.addr);
            if (i % 2 == 0) q0.push_back(c); else q1.push_back(c);
        end
        lat = $urandom_range(0, 4);
        do_traffic("random_write");
        for (int i = 0; i < 20; i++) begin
            c.wr = 1'b0;
            c.addr = addrs[$urandom_range(0, addrs.size() - 1)];
            c.data = 8'h00;
            if ($urandom_range(0, 1) == 0) q0.push_back(c); else q1.push_back(c);
        end
        lat = $urandom_range(0, 4);
        do_traffic("random_read");
    endtask

    task automatic start_stalled_read(input logic [ADDR_W-1:0] a);
        stall = 1'b1;
        ilog.delete(); vlog.delete(); errlog.delete();
        q0.push_back('{1'b0, a, 8'h00});
        set_inputs();
        wait_gnt(0, "stalled_read");
        model_last = 0;
    endtask

    task automatic test_mid_read_reset();
        start_stalled_read(17'h00777);
`ifdef BRAM_ARB_TIMEOUT_EN
        q1.push_back('{1'b1, 17'h00778, 8'h5A});
        set_inputs();
        wait_gnt(1, "timeout_pending");
        exp_mem[17'h00778] = 8'h5A;
        model_last = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ilog.size() != 2 || errlog.size() != 1 || vlog.size() != 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d issues %0d rd_err %0d vld, required 2 1 1", ilog.size(), errlog.size(), vlog.size());
        end else begin
            checks++;
            if (errlog[0] != ilog[0].cyc + 16 || vlog[0].cyc != errlog[0] || vlog[0].port != 0 || vlog[0].data !== 8'h00) begin
                errors++;
                $display("FAIL timeout_pulse: got rd_err cycle %0d vld cycle %0d port %0d data %h, required cycle %0d port 0 data 00",
                         errlog[0], vlog[0].cyc, vlog[0].port, vlog[0].data, ilog[0].cyc + 16);
            end
            checks++;
            if (ilog[1].port != 1 || ilog[1].cyc != ilog[0].cyc + 17) begin
                errors++;
                $display("FAIL timeout_next_gnt: got port %0d cycle %0d, required port 1 cycle %0d", ilog[1].port, ilog[1].cyc, ilog[0].cyc + 17);
            end
        end
        start_stalled_read(17'h00779);
        repeat (3) @(posedge clk);
        #1;
`else
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || rd_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_wait[%0d]: got busy %0b rd_err %0b, required busy 1 rd_err 0", i, busy, rd_err);
            end
        end
`endif
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rdata_vld0, rdata_vld1, rdata, en, wr, addr_in, wdata_in, busy, rd_err} !== '0) begin
            errors++;
            $display("FAIL mid_read_async_reset: got busy %0b en %0b, required all outputs 0", busy, en);
        end
        stall = 1'b0;
        #10 rst_n = 1'b1;
        model_last = 1;
        vlog.delete();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (vlog.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_no_vld: got %0d rdata_vld pulses busy %0b, required 0 and 0", vlog.size(), busy);
        end
    endtask

    task automatic test_after_reset();
        spur = 1'b1;
        repeat (3) @(posedge clk);
        #1 spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vlog.size() != 0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL idle_rdy_ignored: got %0d pulses rdata %h, required 0 pulses rdata 00", vlog.size(), rdata);
        end
        q0.push_back('{1'b1, 17'h00400, 8'h77});
        q1.push_back('{1'b1, 17'h00401, 8'h88});
        do_traffic("rr_after_reset");
        checks++;
        if (ilog.size() < 1 || ilog[0].port != 0) begin
            errors++;
            $display("FAIL rr_first_winner: got port %0d, required port 0", (ilog.size() > 0) ? ilog[0].port : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_read_in_flight();
        test_random();
        test_mid_read_reset();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
